id_ex_hazard_ctrl: RTL and testbench



---
 rtl/id_ex_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_id_ex_hazard_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_ctrl.sv
// ID-stage hazard controller: load-use/branch stalls, taken flushes, mult/div holds.
// Define HAZARD_STALL_CNT_EN to build the saturating stall-cycle counter on StallCount.
module id_ex_hazard_ctrl #(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 3
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRs,
  input  logic        ID_UsesRt,
  input  logic        ID_Branch,
  input  logic        ID_Taken,
  input  logic        EX_MemRead,
  input  logic        EX_RegWrite,
  input  logic [4:0]  EX_WriteReg,
  input  logic        EX_MulDiv,
  input  logic        MEM_MemRead,
  input  logic [4:0]  MEM_WriteReg,
  output logic        PCWrite,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Write,
  output logic        IDEX_Bubble,
  output logic        EXMEM_Bubble,
  output logic        MulDivBusy,
  output logic [31:0] StallCount
);

  typedef enum logic {ST_RUN, ST_WAIT} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               m_ex, m_mem, stall, muldiv_entry;

  always_comb begin
    m_ex  = (EX_WriteReg != 5'd0) &&
            ((ID_UsesRs && (ID_Rs == EX_WriteReg)) || (ID_UsesRt && (ID_Rt == EX_WriteReg)));
    m_mem = (MEM_WriteReg != 5'd0) &&
            ((ID_UsesRs && (ID_Rs == MEM_WriteReg)) || (ID_UsesRt && (ID_Rt == MEM_WriteReg)));
    stall = (EX_MemRead && m_ex) || (ID_Branch && EX_RegWrite && m_ex) ||
            (ID_Branch && MEM_MemRead && m_mem);
    muldiv_entry = EX_MulDiv && (MULDIV_LAT > 1);
  end

  // NOTE: every output gets a default before the priority chain so no latch is inferred.
  always_comb begin
    PCWrite      = 1'b0;
    IFID_Write   = 1'b0;
    IFID_Flush   = 1'b0;
    IDEX_Write   = 1'b0;
    IDEX_Bubble  = 1'b1;
    EXMEM_Bubble = 1'b1;
    if (Rst_n) begin
      if (state_q == ST_WAIT || muldiv_entry) begin
        IDEX_Bubble  = 1'b0;
      end else if (stall) begin
        IDEX_Write   = 1'b1;
        EXMEM_Bubble = 1'b0;
      end else begin
        PCWrite      = 1'b1;
        IFID_Write   = 1'b1;
        IFID_Flush   = ID_Taken;
        IDEX_Write   = 1'b1;
        IDEX_Bubble  = 1'b0;
        EXMEM_Bubble = 1'b0;
      end
    end
  end

  assign MulDivBusy = Rst_n && (state_q == ST_WAIT);

  // The entry cycle is the first hold cycle, so WAIT lasts MULDIV_LAT-2 cycles;
  // cnt holds the WAIT cycles left including the current one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (muldiv_entry && (MULDIV_LAT > 2)) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(MULDIV_LAT - 2);
        end
      end
      ST_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt_q <= '0;
    end else if (!PCWrite && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign StallCount = stall_cnt_q;
`else
  assign StallCount = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Directed bench for id_ex_hazard_ctrl with hand-computed output vectors.
// Inputs change on the falling edge; outputs are compared 1ns later.
module tb_id_ex_hazard_ctrl;

  logic        Clk, Rst_n;
  logic [4:0]  ID_Rs, ID_Rt, EX_WriteReg, MEM_WriteReg;
  logic        ID_UsesRs, ID_UsesRt, ID_Branch, ID_Taken;
  logic        EX_MemRead, EX_RegWrite, EX_MulDiv, MEM_MemRead;
  logic        PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Bubble, MulDivBusy;
  logic [31:0] StallCount;

  int total = 0;
  int bad   = 0;

  // {PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Bubble, MulDivBusy}
  localparam logic [6:0] V_RST   = 7'b0000110;
  localparam logic [6:0] V_NORM  = 7'b1101000;
  localparam logic [6:0] V_STALL = 7'b0001100;
  localparam logic [6:0] V_FLUSH = 7'b1111000;
  localparam logic [6:0] V_HOLD  = 7'b0000010;
  localparam logic [6:0] V_BUSY  = 7'b0000011;

`ifdef HAZARD_STALL_CNT_EN
  localparam logic [31:0] OP_STALLS = 32'd3;
`else
  localparam logic [31:0] OP_STALLS = 32'd0;
`endif

  id_ex_hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(3)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_Branch(ID_Branch), .ID_Taken(ID_Taken),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg),
    .EX_MulDiv(EX_MulDiv), .MEM_MemRead(MEM_MemRead), .MEM_WriteReg(MEM_WriteReg),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Write(IDEX_Write), .IDEX_Bubble(IDEX_Bubble), .EXMEM_Bubble(EXMEM_Bubble),
    .MulDivBusy(MulDivBusy), .StallCount(StallCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Bubble, MulDivBusy};
    check(tag, {25'd0, obs}, {25'd0, exp});
  endtask

  task automatic clear_inputs();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
    ID_Branch = 1'b0; ID_Taken = 1'b0;
    EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_WriteReg = 5'd0; EX_MulDiv = 1'b0;
    MEM_MemRead = 1'b0; MEM_WriteReg = 5'd0;
  endtask

  task automatic next_cycle();
    @(negedge Clk);
    clear_inputs();
  endtask

  initial begin
    Rst_n = 1'b0;
    clear_inputs();
    #1;
    check_outs("reset_outs", V_RST);
    check("reset_cnt", StallCount, 32'd0);

    next_cycle(); Rst_n = 1'b1; #1;
    check_outs("idle", V_NORM);

    // load-use on rs, then EX holds the bubble
    next_cycle();
    EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = 5'd8; ID_Rs = 5'd8; ID_UsesRs = 1'b1; #1;
    check_outs("load_use", V_STALL);
    next_cycle();
    MEM_MemRead = 1'b1; MEM_WriteReg = 5'd8; ID_Rs = 5'd8; ID_UsesRs = 1'b1; #1;
    check_outs("load_use_after", V_NORM);

    next_cycle();
    EX_MemRead = 1'b1; EX_WriteReg = 5'd0; ID_Rs = 5'd0; ID_UsesRs = 1'b1; #1;
    check_outs("reg0_no_stall", V_NORM);

    next_cycle();
    EX_MemRead = 1'b1; EX_WriteReg = 5'd8; ID_Rs = 5'd8; ID_UsesRs = 1'b0; #1;
    check_outs("rs_unused", V_NORM);

    // dependent branch behind a load: two stalls, then the taken flush
    next_cycle();
    ID_Branch = 1'b1; ID_Rt = 5'd9; ID_UsesRt = 1'b1; ID_Taken = 1'b1;
    EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = 5'd9; #1;
    check_outs("br_load_stall1", V_STALL);
    next_cycle();
    ID_Branch = 1'b1; ID_Rt = 5'd9; ID_UsesRt = 1'b1; ID_Taken = 1'b1;
    MEM_MemRead = 1'b1; MEM_WriteReg = 5'd9; #1;
    check_outs("br_load_stall2", V_STALL);
    next_cycle();
    ID_Branch = 1'b1; ID_Rt = 5'd9; ID_UsesRt = 1'b1; ID_Taken = 1'b1; #1;
    check_outs("br_taken_flush", V_FLUSH);
    next_cycle(); #1;
    check_outs("after_flush", V_NORM);

    next_cycle();
    ID_Branch = 1'b1; ID_Rs = 5'd3; ID_UsesRs = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = 5'd3; #1;
    check_outs("br_alu_stall", V_STALL);

    // priority: mult/div entry beats stall and taken, then two WAIT cycles
    next_cycle();
    EX_MulDiv = 1'b1; EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = 5'd4;
    ID_Rs = 5'd4; ID_UsesRs = 1'b1; ID_Taken = 1'b1; #1;
    check_outs("prio_entry", V_HOLD);
    next_cycle();
    ID_Taken = 1'b1; #1;
    check_outs("prio_wait1", V_BUSY);
    next_cycle(); #1;
    check_outs("prio_wait2", V_BUSY);
    next_cycle(); #1;
    check_outs("prio_resume", V_NORM);

    // reset dropped in the second WAIT cycle
    next_cycle();
    EX_MulDiv = 1'b1; #1;
    check_outs("rst_op_entry", V_HOLD);
    next_cycle(); #1;
    check_outs("rst_op_wait1", V_BUSY);
    next_cycle(); #1;
    check_outs("rst_op_wait2", V_BUSY);
    Rst_n = 1'b0; #1;
    check_outs("rst_mid_wait", V_RST);
    check("rst_mid_wait_cnt", StallCount, 32'd0);
    next_cycle(); #1;
    check_outs("rst_held", V_RST);
    next_cycle(); Rst_n = 1'b1; #1;
    check_outs("rst_release", V_NORM);
    check("cnt_after_reset", StallCount, 32'd0);

    // one full op from a cleared counter
    next_cycle();
    EX_MulDiv = 1'b1; #1;
    check_outs("full_entry", V_HOLD);
    next_cycle(); #1;
    check_outs("full_wait1", V_BUSY);
    next_cycle(); #1;
    check_outs("full_wait2", V_BUSY);
    next_cycle(); #1;
    check_outs("full_resume", V_NORM);
    check("cnt_full_op", StallCount, OP_STALLS);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
